// File: rtl/obj_detect_ctrl_if.sv
// Sensor inputs, direction report handshake and status outputs of obj_detect_ctrl.
// master = the controller side, slave = the sensor/consumer side.
interface obj_detect_ctrl_if;
    logic       front_sensor;
    logic       left_sensor;
    logic       right_sensor;
    logic       back_sensor;
    logic       dir_valid;
    logic [2:0] dir_code;
    logic       dir_ack;
    logic       invalid_combo;
    logic [7:0] event_count;

    modport master (
        input  front_sensor, left_sensor, right_sensor, back_sensor, dir_ack,
        output dir_valid, dir_code, invalid_combo, event_count
    );

    modport slave (
        output front_sensor, left_sensor, right_sensor, back_sensor, dir_ack,
        input  dir_valid, dir_code, invalid_combo, event_count
    );
endinterface

// File: rtl/obj_detect_ctrl.sv
// Purpose: synchronize + debounce four object sensors, report one direction code per new pattern.
// Latency: raw change to stab in DEBOUNCE+2 edges, stab to dir_valid in 1 edge (2 from WAIT_CHANGE).
// Backpressure: a report is held until dir_ack; sensor changes meanwhile are not queued.
module obj_detect_ctrl #(
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              reset,
    obj_detect_ctrl_if.master bus
);
    localparam logic [7:0] DEB_CNT = 8'(DEBOUNCE);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REPORT      = 2'd1,
        WAIT_CHANGE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] raw_vec, sync1, sync2, cand, stab, rep_vec;
    logic [7:0] deb_cnt, event_cnt;
    logic [2:0] stab_code, code_q;
    logic       stab_valid, stab_inv;
    logic       stab_upd, inv_pulse;
    logic       load_rep, take_ack;

    assign raw_vec = {bus.front_sensor, bus.left_sensor, bus.right_sensor, bus.back_sensor};

    // stab loads on the edge the run-length counter reaches DEBOUNCE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 4'd0;
            sync2    <= 4'd0;
            cand     <= 4'd0;
            stab     <= 4'd0;
            deb_cnt  <= 8'd0;
            stab_upd <= 1'b0;
        end else begin
            sync1    <= raw_vec;
            sync2    <= sync1;
            stab_upd <= 1'b0;
            if (sync2 != cand) begin
                cand    <= sync2;
                deb_cnt <= 8'd1;
            end else if (deb_cnt < DEB_CNT) begin
                deb_cnt <= deb_cnt + 8'd1;
                if (deb_cnt + 8'd1 == DEB_CNT) begin
                    stab     <= cand;
                    stab_upd <= (cand != stab);
                end
            end
        end
    end

    always_comb begin
        stab_code  = 3'd0;
        stab_valid = 1'b1;
        stab_inv   = 1'b0;
        case (stab)
            4'b1000: stab_code = 3'd0;
            4'b0100: stab_code = 3'd1;
            4'b0010: stab_code = 3'd2;
            4'b0001: stab_code = 3'd3;
            4'b1010: stab_code = 3'd4;
            4'b1100: stab_code = 3'd5;
            4'b0011: stab_code = 3'd6;
            4'b0101: stab_code = 3'd7;
            4'b0000: stab_valid = 1'b0;
            default: begin
                stab_valid = 1'b0;
                stab_inv   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_pulse <= 1'b0;
        end else begin
            inv_pulse <= stab_upd && stab_inv;
        end
    end

    always_comb begin
        state_nxt = state;
        load_rep  = 1'b0;
        take_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (stab_valid) begin
                    load_rep  = 1'b1;
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (bus.dir_ack) begin
                    take_ack  = 1'b1;
                    state_nxt = WAIT_CHANGE;
                end
            end
            WAIT_CHANGE: begin
                if (stab != rep_vec) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            code_q    <= 3'd0;
            rep_vec   <= 4'd0;
            event_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (load_rep) begin
                code_q  <= stab_code;
                rep_vec <= stab;
            end
            if (take_ack && event_cnt != 8'hFF) begin
                event_cnt <= event_cnt + 8'd1;
            end
        end
    end

    assign bus.dir_valid     = (state == REPORT);
    assign bus.dir_code      = code_q;
    assign bus.invalid_combo = inv_pulse;
    assign bus.event_count   = event_cnt;
endmodule

// File: tb/tb_obj_detect_ctrl.sv
// Randomized bench for obj_detect_ctrl: stimulus feeds a behavioural model that queues expected
// reports, invalid pulses and acknowledged counts; a negedge monitor pops and compares.
module tb_obj_detect_ctrl;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    obj_detect_ctrl_if bus ();

    obj_detect_ctrl #(.DEBOUNCE(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int cyc;
        int val;
    } exp_t;

    exp_t rep_q[$];
    exp_t ack_q[$];
    int   inv_q[$];

    // Reference model state: raw history, stable pattern, pending/waiting report
    int         lut[16];
    logic [3:0] hist[$];
    logic [3:0] m_stab, m_rep;
    bit         m_pend, m_wait, m_inv_next;
    int         m_count;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(4'd0);
        m_stab = 4'd0; m_rep = 4'd0;
        m_pend = 0; m_wait = 0; m_inv_next = 0;
        m_count = 0;
    endtask

    // Predict everything that happens at edge e, given the raw inputs present before it.
    task automatic model_edge(input logic [3:0] v, input bit ack, input int e);
        logic [3:0] w, new_stab;
        bit         steady;
        exp_t       x;
        hist.push_back(v);
        while (hist.size() > DEB + 2) void'(hist.pop_front());
        // stab follows a raw value once it was seen DEB edges in a row, two edges back
        w = hist[hist.size() - 3];
        steady = 1;
        for (int j = 2; j <= DEB + 1; j++)
            if (hist[hist.size() - 1 - j] != w) steady = 0;
        new_stab = steady ? w : m_stab;

        if (m_inv_next) inv_q.push_back(e);
        m_inv_next = (new_stab != m_stab) && (lut[new_stab] == -2);

        if (m_pend) begin
            if (ack) begin
                m_pend = 0;
                m_wait = 1;
                m_count = (m_count >= 255) ? 255 : m_count + 1;
                x.cyc = e; x.val = m_count;
                ack_q.push_back(x);
            end
        end else if (m_wait) begin
            if (m_stab != m_rep) m_wait = 0;
        end else if (lut[m_stab] >= 0) begin
            m_pend = 1;
            m_rep  = m_stab;
            x.cyc = e; x.val = lut[m_stab];
            rep_q.push_back(x);
        end
        m_stab = new_stab;
    endtask

    // Called at posedge+1; drives inputs for the next edge and advances to posedge+1 again.
    task automatic step(input logic [3:0] v, input int ack_mode);
        bit a;
        a = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
        bus.front_sensor = v[3];
        bus.left_sensor  = v[2];
        bus.right_sensor = v[1];
        bus.back_sensor  = v[0];
        bus.dir_ack      = a;
        model_edge(v, a, cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] v, input int ack_mode, input int n);
        for (int i = 0; i < n; i++) step(v, ack_mode);
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1;
        chk("async_reset_dir_valid", int'(bus.dir_valid), 0);
        chk("async_reset_event_count", int'(bus.event_count), 0);
        chk("async_reset_dir_code", int'(bus.dir_code), 0);
        model_reset();
        #1 reset = 1'b0;
    endtask

    // Monitor
    logic hs = 1'b0;
    logic prev_valid = 1'b0;
    exp_t mon_e;

    always @(posedge clk) hs <= bus.dir_valid && bus.dir_ack;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.dir_valid && !prev_valid) begin
                if (rep_q.size() == 0) chk("unexpected_report", int'(bus.dir_code), -1);
                else begin
                    mon_e = rep_q.pop_front();
                    chk("report_cycle", cyc, mon_e.cyc);
                    chk("report_code", int'(bus.dir_code), mon_e.val);
                end
            end
            while (rep_q.size() > 0 && rep_q[0].cyc < cyc) begin
                mon_e = rep_q.pop_front();
                chk("report_missing_at_cycle", -1, mon_e.cyc);
            end
            if (bus.invalid_combo) begin
                if (inv_q.size() == 0) chk("unexpected_invalid_combo", cyc, -1);
                else chk("invalid_combo_cycle", cyc, inv_q.pop_front());
            end
            while (inv_q.size() > 0 && inv_q[0] < cyc)
                chk("invalid_combo_missing_at_cycle", -1, inv_q.pop_front());
            if (hs) begin
                if (ack_q.size() == 0) chk("unexpected_handshake", cyc, -1);
                else begin
                    mon_e = ack_q.pop_front();
                    chk("ack_cycle", cyc, mon_e.cyc);
                    chk("ack_event_count", int'(bus.event_count), mon_e.val);
                    chk("ack_drops_valid", int'(bus.dir_valid), 0);
                end
            end
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                mon_e = ack_q.pop_front();
                chk("ack_missing_at_cycle", -1, mon_e.cyc);
            end
        end
        prev_valid = bus.dir_valid;
    end

    initial begin
        for (int i = 0; i < 16; i++) lut[i] = -2;
        lut[0] = -1;
        lut[8] = 0; lut[4] = 1; lut[2] = 2; lut[1] = 3;
        lut[10] = 4; lut[12] = 5; lut[3] = 6; lut[5] = 7;
        bus.front_sensor = 1'b0; bus.left_sensor = 1'b0;
        bus.right_sensor = 1'b0; bus.back_sensor = 1'b0;
        bus.dir_ack = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_dir_valid", int'(bus.dir_valid), 0);
        chk("reset_dir_code", int'(bus.dir_code), 0);
        chk("reset_invalid_combo", int'(bus.invalid_combo), 0);
        chk("reset_event_count", int'(bus.event_count), 0);
        reset = 1'b0;

        // front held, then acknowledged
        hold(4'b1000, 0, 10);
        hold(4'b1000, 1, 3);
        chk("front_event_count", int'(bus.event_count), 1);
        hold(4'b0000, 0, 10);

        // short right glitch never reaches the stable vector
        hold(4'b0010, 0, DEB - 1);
        hold(4'b0000, 0, 10);

        // front+back is invalid, then back released
        hold(4'b1001, 0, 10);
        hold(4'b1000, 0, 10);
        hold(4'b1000, 1, 2);
        hold(4'b0000, 0, 10);

        // back+left pending while the sensors move to front only
        hold(4'b0101, 0, 10);
        hold(4'b1000, 0, 12);
        chk("unacked_code_held", int'(bus.dir_code), 7);
        hold(4'b1000, 1, 1);
        hold(4'b1000, 0, 3);
        hold(4'b1000, 1, 2);
        hold(4'b0000, 0, 10);

        // 300 alternating left/right handshakes saturate the counter
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 4'b0100 : 4'b0010, 1, 12);
        chk("event_count_saturated", int'(bus.event_count), 255);
        hold(4'b0000, 0, 10);

        // reset while a report is pending, sensor kept asserted
        hold(4'b0100, 0, 10);
        chk("pre_reset_pending", int'(bus.dir_valid), 1);
        pulse_reset();
        hold(4'b0100, 0, 10);
        hold(4'b0100, 1, 2);
        chk("post_reset_event_count", int'(bus.event_count), 1);
        hold(4'b0000, 0, 10);

        // random patterns, random hold lengths, random acks
        for (int i = 0; i < 80; i++) begin
            logic [3:0] v;
            int         n;
            v = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 8);
            hold(v, 2, n);
        end
        hold(4'b0000, 1, 20);

        chk("report_queue_drained", rep_q.size(), 0);
        chk("invalid_queue_drained", inv_q.size(), 0);
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("final_event_count", int'(bus.event_count), m_count);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
